// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// mem_responder_pkg : shared encodings and defaults for the memory responder
// Revision: 1.0
// ============================================================================
package mem_responder_pkg;

    localparam int ADDRESS_INDEX_LIMIT = 25;
    localparam int DATA_INDEX_LIMIT    = 31;
    localparam int MEM_LATENCY_DEFAULT = 2;
    localparam int MEM_DEPTH_DEFAULT   = 1024;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE = 2'b00,
        MEM_STATE_WAIT = 2'b01,
        MEM_STATE_RESP = 2'b10
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// mem_responder_if : processor <-> memory request/response bundle
// Revision: 1.0
// ============================================================================
interface mem_responder_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DATA_IN;
    logic              READ;
    logic              WRITE;
    logic [DATA_W-1:0] DATA_OUT;
    logic              DONE;
    logic              BUSY;
    logic              ERR;

    modport master (
        output ADDR, DATA_IN, READ, WRITE,
        input  DATA_OUT, DONE, BUSY, ERR
    );

    modport slave (
        input  ADDR, DATA_IN, READ, WRITE,
        output DATA_OUT, DONE, BUSY, ERR
    );
endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// mem_array : single-port synchronous RAM, registered read data, no reset
// Revision: 1.0
// ============================================================================
module mem_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  wire logic              CLK,
    input  wire logic              i_we,
    input  wire logic              i_re,
    input  wire logic [IDX_W-1:0]  i_idx,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// mem_responder : one-at-a-time memory responder with programmable wait states
// Revision: 1.0
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int                ADDR_W    = ADDRESS_INDEX_LIMIT + 1,
    parameter int                DATA_W    = DATA_INDEX_LIMIT + 1,
    parameter int                DEPTH     = MEM_DEPTH_DEFAULT,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                LATENCY   = MEM_LATENCY_DEFAULT
) (
    input wire logic       CLK,
    input wire logic       RST,
    mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    mem_state_t        r_state, w_state_nxt;
    logic [3:0]        r_count, w_count_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_write;
    logic              r_err, w_err_nxt;
    logic              r_zero;
    logic              w_enter_resp;
    logic              w_req_ok, w_req_bad;
    logic [ADDR_W-1:0] w_addr, w_idx;
    logic              w_borrow, w_in_range, w_is_write;
    logic [DATA_W-1:0] w_rdata;

    assign w_req_ok  = bus.READ ^ bus.WRITE;
    assign w_req_bad = bus.READ & bus.WRITE;

    // In IDLE the live request is used so a zero-latency access can complete on its accept edge.
    assign w_addr     = (r_state == MEM_STATE_IDLE) ? bus.ADDR  : r_addr;
    assign w_is_write = (r_state == MEM_STATE_IDLE) ? bus.WRITE : r_is_write;
    assign {w_borrow, w_idx} = {1'b0, w_addr} - {1'b0, BASE_ADDR};
    assign w_in_range = !w_borrow && (w_idx < ADDR_W'(DEPTH));

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_enter_resp = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            MEM_STATE_IDLE: begin
                if (w_req_ok) begin
                    if (LATENCY == 0) begin
                        w_state_nxt  = MEM_STATE_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = MEM_STATE_WAIT;
                        w_count_nxt = 4'(LATENCY);
                    end
                end else if (w_req_bad) begin
                    w_err_nxt = 1'b1;
                end
            end
            MEM_STATE_WAIT: begin
                w_count_nxt = r_count - 4'd1;
                if (r_count == 4'd1) begin
                    w_state_nxt  = MEM_STATE_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            MEM_STATE_RESP: begin
                w_state_nxt = MEM_STATE_IDLE;
            end
            default: begin
                w_state_nxt = MEM_STATE_IDLE;
            end
        endcase
        if (w_enter_resp && !w_in_range) begin
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= MEM_STATE_IDLE;
            r_count    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_err      <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
            if (r_state == MEM_STATE_IDLE && w_req_ok) begin
                r_addr     <= bus.ADDR;
                r_wdata    <= bus.DATA_IN;
                r_is_write <= bus.WRITE;
            end
            // Out-of-range reads present zero instead of the stale RAM read register.
            if (w_enter_resp && !w_is_write) begin
                r_zero <= !w_in_range;
            end
        end
    end

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .CLK     (CLK),
        .i_we    (!RST && r_state == MEM_STATE_RESP && r_is_write && w_in_range),
        .i_re    (!RST && w_enter_resp && !w_is_write && w_in_range),
        .i_idx   (w_idx[IDX_W-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign bus.DATA_OUT = r_zero ? '0 : w_rdata;
    assign bus.DONE     = (r_state == MEM_STATE_RESP);
    assign bus.BUSY     = (r_state != MEM_STATE_IDLE);
    assign bus.ERR      = r_err;
endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's memory interface (ADDR, DATA, READ, WRITE).
- Accepts one read or write request at a time and services it after a programmable number of wait states.
- Returns read data and a one-cycle DONE completion pulse.
- Sits between the processor top level and the word-addressed memory array; replaces the zero-latency behavioural memory in system-level benches.

Parameters:
- ADDR_W, 26, address width (matches ADDRESS_INDEX_LIMIT+1).
- DATA_W, 32, data width (matches DATA_INDEX_LIMIT+1).
- DEPTH, 1024, number of words in the array.
- BASE_ADDR, 26'h0000000, first word address mapped to this array.
- LATENCY, 2, wait-state cycles between request acceptance and response (0..15).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- ADDR  input  ADDR_W  word address of the request.
- DATA_IN  input  DATA_W  write data from the processor.
- READ  input  1  read request level.
- WRITE  input  1  write request level.
- DATA_OUT  output  DATA_W  read data returned to the processor.
- DONE  output  1  one-cycle completion pulse.
- BUSY  output  1  request in progress; new requests are ignored.
- ERR  output  1  error pulse: out-of-range access or illegal READ&WRITE.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset values: state IDLE; DATA_OUT=0, DONE=0, BUSY=0, ERR=0; counter=0. Array contents are not cleared.
- Reset mid-operation: any pending write is dropped and the next cycle is IDLE.
- States: IDLE, WAIT, RESP. Encoding is binary, 2 bits.
- IDLE:
  - Request is sampled at rising edge t0 when exactly one of READ/WRITE is high.
  - At t0, latch ADDR, DATA_IN and op.
  - LATENCY=0 -> RESP; otherwise -> WAIT with counter=LATENCY.
- IDLE with READ=WRITE=1: request not accepted, state stays IDLE, ERR=1 for the one following cycle.
- WAIT: counter decrements each edge; when counter==1 the next edge enters RESP. RESP is always entered at edge t0+LATENCY.
- RESP:
  - DONE=1 for exactly one cycle; next edge -> IDLE unconditionally.
  - Read: DATA_OUT is loaded on the edge entering RESP and held until the next read enters RESP (writes do not disturb it).
  - Write: array is updated on the edge leaving RESP; a read to the same word issued afterwards returns the new data.
- BUSY=1 in WAIT and RESP, 0 in IDLE. READ/WRITE while BUSY are ignored, with no queueing.
- A request held high across RESP->IDLE is re-accepted on the IDLE edge. Back-to-back throughput is one request per LATENCY+2 cycles.
- Range check:
  - idx = latched ADDR - BASE_ADDR, unsigned, ADDR_W bits.
  - In range iff ADDR >= BASE_ADDR and idx < DEPTH.
  - Out-of-range read: DATA_OUT loads 0.
  - Out-of-range write: array untouched.
  - Both: DONE=1 and ERR=1 in the same RESP cycle.
- Outputs DONE, BUSY, ERR are Moore, decoded from registered state/flags with no combinational path from inputs.

Decomposition:
- Shared include (prj_definition.v): add MEM_STATE_IDLE/WAIT/RESP encodings, MEM_LATENCY_DEFAULT, and MEM_DEPTH_DEFAULT. Reuse the existing ADDRESS/DATA index limits.
- Sub-module mem_array: single-port synchronous RAM, DEPTH x DATA_W, with write-enable, index, write data and registered read data. The responder FSM and counter live in mem_responder.

Test Plan:
- Reset then idle, LATENCY=2 -> DATA_OUT=0, DONE/BUSY/ERR=0 for 5 cycles.
- WRITE ADDR=0x10 DATA_IN=0xDEADBEEF at t0, then READ 0x10 once BUSY drops -> write DONE at t0+2; read DONE 2 cycles after its accept with DATA_OUT=0xDEADBEEF; BUSY high exactly 3 cycles per request.
- LATENCY=0, READ held high continuously at ADDR=0x10 -> DONE pulses every 2nd cycle, DATA_OUT stable at 0xDEADBEEF.
- READ and WRITE both high in IDLE -> ERR=1 one cycle, DONE=0, BUSY=0, array unchanged.
- READ ADDR=BASE_ADDR+DEPTH (1024) -> DONE=1 and ERR=1 same cycle, DATA_OUT=0. WRITE there then read word 0 -> word 0 unchanged.
- WRITE 0x20=0x12345678 accepted, RST asserted during WAIT -> next cycle IDLE, all outputs 0; subsequent READ 0x20 returns the prior contents, not 0x12345678.
